keypad_scanner: RTL

- Input-side counterpart to the multiplexed seven-segment driver.
- Scans a 4x4 active-low matrix keypad (Pmod KYPD style): drives one column low at a time and samples the four rows.
- Debounces the result across whole scans, decodes it to a 4-bit hex key code, and produces press/release strobes.
- Keeps a 4-digit key history whose output ports wire directly to the display driver's dataIn and digitDisplay inputs.

---
 rtl/keypad_scanner.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner. It drives one column low at a time and samples the
// synchronized rows. Whole-scan results are debounced and decoded to a hex key code with
// press/release strobes. A four-digit history feeds a multiplexed seven-segment driver.
module keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES  = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_i,
    input  logic        clear_i,
    output logic [3:0]  col_o,
    output logic [3:0]  key_code_o,
    output logic        key_down_o,
    output logic        key_valid_o,
    output logic        key_release_o,
    output logic [15:0] key_history_o,
    output logic [3:0]  digits_valid_o
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] DwellLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [3:0] StableMax = 4'(DEBOUNCE_SCANS);

    typedef enum logic [0:0] {StIdle, StPressed} state_e;

    logic [3:0]      rows_meta_q, rows_s_q;
    logic [CntW-1:0] dwell_q;
    logic [1:0]      col_idx_q;
    logic [3:0][3:0] slot_q;
    logic            scan_done_q;
    logic            sample_edge;

    logic            scan_pressed;
    logic [3:0]      scan_code;
    logic [4:0]      scan_res;
    logic [4:0]      cand_q, cand_d;
    logic [3:0]      stable_q, stable_d;
    logic            first_stable;

    state_e          state_q, state_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_down_q, key_down_d;
    logic            key_valid_q, key_valid_d;
    logic            key_release_q, key_release_d;
    logic [15:0]     history_q;
    logic [3:0]      digits_valid_q;

    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] k;
        unique case ({c, r})
            4'h0: k = 4'h1;
            4'h1: k = 4'h4;
            4'h2: k = 4'h7;
            4'h3: k = 4'h0;
            4'h4: k = 4'h2;
            4'h5: k = 4'h5;
            4'h6: k = 4'h8;
            4'h7: k = 4'hF;
            4'h8: k = 4'h3;
            4'h9: k = 4'h6;
            4'hA: k = 4'h9;
            4'hB: k = 4'hE;
            4'hC: k = 4'hA;
            4'hD: k = 4'hB;
            4'hE: k = 4'hC;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_meta_q <= 4'b1111;
            rows_s_q    <= 4'b1111;
        end else begin
            rows_meta_q <= row_i;
            rows_s_q    <= rows_meta_q;
        end
    end

    assign sample_edge = (dwell_q == DwellLast);

    // Column dwell counter, column advance, per-column row capture and end-of-scan strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            slot_q      <= '1;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= sample_edge && (col_idx_q == 2'd3);
            if (sample_edge) begin
                slot_q[col_idx_q] <= rows_s_q;
                dwell_q           <= '0;
                col_idx_q         <= col_idx_q + 2'd1;
            end else begin
                dwell_q <= dwell_q + CntW'(1);
            end
        end
    end

    assign col_o = ~(4'b0001 << col_idx_q);

    // Priority-encode the captured scan; walking downward lets the lowest column/row win.
    always_comb begin
        scan_pressed = 1'b0;
        scan_code    = 4'h0;
        for (int c = 3; c >= 0; c--) begin
            for (int r = 3; r >= 0; r--) begin
                if (!slot_q[c][r]) begin
                    scan_pressed = 1'b1;
                    scan_code    = key_map(2'(c), 2'(r));
                end
            end
        end
    end

    assign scan_res = {scan_pressed, scan_code};

    // Debounce: count identical scans; flag only the scan where the count first saturates.
    always_comb begin
        cand_d       = cand_q;
        stable_d     = stable_q;
        first_stable = 1'b0;
        if (scan_done_q) begin
            if (scan_res == cand_q) begin
                if (stable_q != StableMax) stable_d = stable_q + 4'd1;
            end else begin
                cand_d   = scan_res;
                stable_d = 4'd1;
            end
            first_stable = (stable_d == StableMax) &&
                           ((stable_q != StableMax) || (scan_res != cand_q));
        end
    end

    // Press/release FSM next-state and registered strobe values.
    always_comb begin
        state_d       = state_q;
        key_code_d    = key_code_q;
        key_down_d    = key_down_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;
        if (first_stable) begin
            unique case (state_q)
                StIdle: begin
                    if (cand_d[4]) begin
                        state_d     = StPressed;
                        key_code_d  = cand_d[3:0];
                        key_down_d  = 1'b1;
                        key_valid_d = 1'b1;
                    end
                end
                StPressed: begin
                    if (!cand_d[4]) begin
                        state_d       = StIdle;
                        key_down_d    = 1'b0;
                        key_release_d = 1'b1;
                    end else if (cand_d[3:0] != key_code_q) begin
                        // Rollover to a different key without an intervening release.
                        key_code_d  = cand_d[3:0];
                        key_valid_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Debounce and FSM state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q        <= '0;
            stable_q      <= '0;
            state_q       <= StIdle;
            key_code_q    <= 4'h0;
            key_down_q    <= 1'b0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            cand_q        <= cand_d;
            stable_q      <= stable_d;
            state_q       <= state_d;
            key_code_q    <= key_code_d;
            key_down_q    <= key_down_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
        end
    end

    // Key history shift; a clear coinciding with a press keeps only the new key.
    always_ff @(posedge clk) begin
        if (reset) begin
            history_q      <= 16'h0000;
            digits_valid_q <= 4'b0000;
        end else if (clear_i) begin
            history_q      <= key_valid_q ? {12'h000, key_code_q} : 16'h0000;
            digits_valid_q <= key_valid_q ? 4'b0001 : 4'b0000;
        end else if (key_valid_q) begin
            history_q      <= {history_q[11:0], key_code_q};
            digits_valid_q <= {digits_valid_q[2:0], 1'b1};
        end
    end

    assign key_code_o     = key_code_q;
    assign key_down_o     = key_down_q;
    assign key_valid_o    = key_valid_q;
    assign key_release_o  = key_release_q;
    assign key_history_o  = history_q;
    assign digits_valid_o = digits_valid_q;

endmodule
